// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shift unit: command encodings,
// FSM state type and the STEP legality helper.
package shifter_pkg;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_t;

  function automatic bit step_legal(input int unsigned s);
    return (s == 1) || (s == 2) || (s == 4) || (s == 8) || (s == 16);
  endfunction

endpackage

// File: rtl/shifter_iter_if.sv
// Issue-side and result-side handshakes of the iterative shift unit.
// The unit itself takes the slave view; issue logic / result mux take master.
interface shifter_iter_if;

  logic        IN_VALID_SE;
  logic        IN_READY_SE;
  logic [31:0] DIN_SE;
  logic [4:0]  SHIFT_VAL_SE;
  logic [1:0]  CMD_SE;
  logic        FLUSH_SE;
  logic        OUT_VALID_SE;
  logic        OUT_READY_SE;
  logic [31:0] DOUT_SE;
  logic        BUSY_SE;

  modport master (
    output IN_VALID_SE, DIN_SE, SHIFT_VAL_SE, CMD_SE, FLUSH_SE, OUT_READY_SE,
    input  IN_READY_SE, OUT_VALID_SE, DOUT_SE, BUSY_SE
  );

  modport slave (
    input  IN_VALID_SE, DIN_SE, SHIFT_VAL_SE, CMD_SE, FLUSH_SE, OUT_READY_SE,
    output IN_READY_SE, OUT_VALID_SE, DOUT_SE, BUSY_SE
  );

endinterface

// File: rtl/shift_step.sv
// Combinational 32-bit shift by 0..STEP bits, one binary-weighted stage per
// amount bit. SRA refills from bit 31 of each stage input (sign is invariant).
module shift_step
  import shifter_pkg::*;
#(
  parameter  int unsigned STEP = 4,
  localparam int unsigned AW   = $clog2(STEP) + 1
) (
  input  logic [31:0]   din,
  input  logic [AW-1:0] amt,
  input  logic [1:0]    cmd,
  output logic [31:0]   dout
);

  logic [31:0] v;

  always_comb begin
    v = din;
    for (int unsigned k = 0; k < AW; k++) begin
      if (amt[k]) begin
        case (cmd)
          SHIFT_SLL:         v = v << (1 << k);
          SHIFT_SRL:         v = v >> (1 << k);
          SHIFT_SRA, 2'b11:  v = 32'($signed(v) >>> (1 << k));
        endcase
      end
    end
    dout = v;
  end

endmodule

// File: rtl/shifter_iter.sv
// Multi-cycle shift unit: accepts an operand, shifts STEP bits per cycle and
// presents the result through a valid/ready handshake. Bit-exact with the barrel shifter.
module shifter_iter
  import shifter_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  shifter_iter_if.slave sif
);

  localparam int unsigned AW = $clog2(STEP) + 1;

  if (!step_legal(STEP)) begin : g_bad_step
    $error("shifter_iter: STEP=%0d must be one of 1, 2, 4, 8, 16", STEP);
  end

  shift_state_t state, state_n;
  logic [31:0]  data, data_n, step_out;
  logic [4:0]   count, count_n, step_amt, count_dec;
  logic [1:0]   cmd, cmd_n;

  // Last step of an operation may be shorter than STEP.
  assign step_amt  = (count >= 5'(STEP)) ? 5'(STEP) : count;
  assign count_dec = count - step_amt;

  shift_step #(.STEP(STEP)) u_step (
    .din  (data),
    .amt  (step_amt[AW-1:0]),
    .cmd  (cmd),
    .dout (step_out)
  );

  always_comb begin
    state_n = state;
    data_n  = data;
    count_n = count;
    cmd_n   = cmd;
    if (sif.FLUSH_SE) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (sif.IN_VALID_SE) begin
            data_n  = sif.DIN_SE;
            count_n = sif.SHIFT_VAL_SE;
            cmd_n   = sif.CMD_SE;
            state_n = (sif.SHIFT_VAL_SE == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          data_n  = step_out;
          count_n = count_dec;
          if (count_dec == '0) state_n = DONE;
        end
        DONE: begin
          if (sif.OUT_READY_SE) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      data  <= '0;
      count <= '0;
      cmd   <= SHIFT_SLL;
    end else begin
      state <= state_n;
      data  <= data_n;
      count <= count_n;
      cmd   <= cmd_n;
    end
  end

  // The data register doubles as the result register; a flush leaves it untouched.
  assign sif.IN_READY_SE  = (state == IDLE);
  assign sif.OUT_VALID_SE = (state == DONE);
  assign sif.BUSY_SE      = (state != IDLE);
  assign sif.DOUT_SE      = data;

  a_dout_stable: assert property (@(posedge CLK) disable iff (RESET)
    (sif.OUT_VALID_SE && !sif.OUT_READY_SE) |=> $stable(sif.DOUT_SE));

  a_no_underflow: assert property (@(posedge CLK) disable iff (RESET)
    (state == SHIFT) |-> ((count != '0) && (step_amt <= count)));

endmodule

// File: tb/tb_shifter_iter.sv
// Directed bench for shifter_iter (STEP=4): shift results, latency,
// back-pressure, flush/reset kills, plus a short randomized model check.
module tb_shifter_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  shifter_iter_if sif ();

  shifter_iter #(.STEP(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .sif   (sif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] n,
                                            input logic [1:0] c);
    case (c)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      default: return 32'($signed(d) >>> n);
    endcase
  endfunction

  task automatic issue(input logic [31:0] d, input logic [4:0] n, input logic [1:0] c);
    sif.DIN_SE       = d;
    sif.SHIFT_VAL_SE = n;
    sif.CMD_SE       = c;
    sif.IN_VALID_SE  = 1'b1;
    tick();
    sif.IN_VALID_SE  = 1'b0;
  endtask

  // Cycles from accept edge until OUT_VALID, bounded; also notes any IN_READY while busy.
  task automatic wait_valid(output int lat, output bit rdy_seen);
    lat = 1;
    rdy_seen = 1'b0;
    while (!sif.OUT_VALID_SE && lat < 64) begin
      if (sif.IN_READY_SE) rdy_seen = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] n,
                        input logic [1:0] c, input logic [31:0] exp, input int exp_lat);
    int lat;
    bit rdy_seen;
    issue(d, n, c);
    wait_valid(lat, rdy_seen);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_dout"}, sif.DOUT_SE, exp);
    check({tag, "_rdy_busy"}, {31'b0, rdy_seen | sif.IN_READY_SE}, 32'd0);
    tick();
    check({tag, "_vfall"}, {31'b0, sif.OUT_VALID_SE}, 32'd0);
  endtask

  initial begin
    int lat;
    bit rdy_seen;
    bit seen;
    logic [31:0] d;
    logic [4:0]  n;
    logic [1:0]  c;

    sif.IN_VALID_SE  = 1'b0;
    sif.DIN_SE       = '0;
    sif.SHIFT_VAL_SE = '0;
    sif.CMD_SE       = '0;
    sif.FLUSH_SE     = 1'b0;
    sif.OUT_READY_SE = 1'b1;

    tick();
    tick();
    check("rst_dout", sif.DOUT_SE, 32'h0);
    check("rst_valid", {31'b0, sif.OUT_VALID_SE}, 32'd0);
    check("rst_busy", {31'b0, sif.BUSY_SE}, 32'd0);
    rst = 1'b0;
    check("rst_ready", {31'b0, sif.IN_READY_SE}, 32'd1);

    run_op("sll31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 9);
    run_op("sra4",  32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 2);
    run_op("srl4",  32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000, 2);
    run_op("sra31", 32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF, 9);
    for (int i = 0; i < 4; i++)
      run_op("amt0", 32'hDEAD_BEEF, 5'd0, 2'(i), 32'hDEAD_BEEF, 1);
    run_op("srl5",  32'h0F0F_0F0F, 5'd5,  2'b01, 32'h0078_7878, 3);
    run_op("sra3p", 32'h7000_0000, 5'd3,  2'b10, 32'h0E00_0000, 2);
    run_op("sll16", 32'h0000_ABCD, 5'd16, 2'b00, 32'hABCD_0000, 5);

    // Back-pressure: result held in DONE, second op waits for the bubble.
    sif.OUT_READY_SE = 1'b0;
    issue(32'h1234_5678, 5'd8, 2'b00);
    wait_valid(lat, rdy_seen);
    check("bp_lat", 32'(lat), 32'd3);
    check("bp_dout", sif.DOUT_SE, 32'h3456_7800);
    sif.DIN_SE       = 32'hFFFF_0000;
    sif.SHIFT_VAL_SE = 5'd4;
    sif.CMD_SE       = 2'b01;
    sif.IN_VALID_SE  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_dout", sif.DOUT_SE, 32'h3456_7800);
      check("bp_hold_ready", {31'b0, sif.IN_READY_SE}, 32'd0);
      check("bp_hold_valid", {31'b0, sif.OUT_VALID_SE}, 32'd1);
    end
    sif.OUT_READY_SE = 1'b1;
    tick();
    check("bp_vfall", {31'b0, sif.OUT_VALID_SE}, 32'd0);
    check("bp_ready", {31'b0, sif.IN_READY_SE}, 32'd1);
    tick();
    sif.IN_VALID_SE = 1'b0;
    wait_valid(lat, rdy_seen);
    check("bp2_lat", 32'(lat), 32'd2);
    check("bp2_dout", sif.DOUT_SE, 32'h0FFF_F000);
    tick();
    check("bp2_vfall", {31'b0, sif.OUT_VALID_SE}, 32'd0);

    // Flush on the second SHIFT cycle of a 31-bit shift.
    issue(32'hFFFF_FFFF, 5'd31, 2'b00);
    tick();
    sif.FLUSH_SE = 1'b1;
    tick();
    sif.FLUSH_SE = 1'b0;
    check("fl_valid", {31'b0, sif.OUT_VALID_SE}, 32'd0);
    check("fl_ready", {31'b0, sif.IN_READY_SE}, 32'd1);
    check("fl_busy", {31'b0, sif.BUSY_SE}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (sif.OUT_VALID_SE) seen = 1'b1;
    end
    check("fl_never_valid", {31'b0, seen}, 32'd0);

    // Flush coinciding with IN_VALID in IDLE: op must be dropped.
    sif.DIN_SE       = 32'h0000_0055;
    sif.SHIFT_VAL_SE = 5'd0;
    sif.CMD_SE       = 2'b00;
    sif.IN_VALID_SE  = 1'b1;
    sif.FLUSH_SE     = 1'b1;
    tick();
    sif.IN_VALID_SE  = 1'b0;
    sif.FLUSH_SE     = 1'b0;
    check("flidle_busy", {31'b0, sif.BUSY_SE}, 32'd0);
    check("flidle_valid", {31'b0, sif.OUT_VALID_SE}, 32'd0);
    tick();
    check("flidle_valid2", {31'b0, sif.OUT_VALID_SE}, 32'd0);

    // Flush in DONE with OUT_READY high voids the handshake, keeps DOUT.
    issue(32'hCAFE_F00D, 5'd0, 2'b01);
    check("fldone_valid_pre", {31'b0, sif.OUT_VALID_SE}, 32'd1);
    sif.FLUSH_SE = 1'b1;
    tick();
    sif.FLUSH_SE = 1'b0;
    check("fldone_valid", {31'b0, sif.OUT_VALID_SE}, 32'd0);
    check("fldone_dout", sif.DOUT_SE, 32'hCAFE_F00D);
    check("fldone_ready", {31'b0, sif.IN_READY_SE}, 32'd1);

    // Reset pulse mid-shift.
    issue(32'h1234_5678, 5'd31, 2'b00);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_dout", sif.DOUT_SE, 32'h0);
    check("mrst_valid", {31'b0, sif.OUT_VALID_SE}, 32'd0);
    check("mrst_busy", {31'b0, sif.BUSY_SE}, 32'd0);
    check("mrst_ready", {31'b0, sif.IN_READY_SE}, 32'd1);

    for (int i = 0; i < 100; i++) begin
      d = $urandom;
      n = 5'($urandom_range(0, 31));
      c = 2'($urandom_range(0, 3));
      run_op("rnd", d, n, c, ref_shift(d, n, c), 1 + (int'(n) + 3) / 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shifter_iter.md
Name: shifter_iter

Overview:
Multi-cycle shift unit for the area-reduced EXE configuration, the sequential counterpart of the single-cycle barrel shifter. It accepts one operand, shift amount and command from the decode/issue side through a valid/ready handshake. It shifts STEP bits per cycle and presents the result to the EXE result mux through a second valid/ready handshake. It is bit-exact with the single-cycle shifter for every CMD/amount combination.

Parameters:
STEP, 4, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8, 16.

Ports:
CLK  input  1  core clock
RESET  input  1  synchronous, active-high reset
IN_VALID_SE  input  1  operand valid from issue
IN_READY_SE  output  1  unit can accept an operand
DIN_SE  input  32  operand to shift
SHIFT_VAL_SE  input  5  shift amount, 0..31
CMD_SE  input  2  00 = SLL, 01 = SRL, 1x = SRA
FLUSH_SE  input  1  pipeline flush; kill in-flight op
OUT_VALID_SE  output  1  result valid
OUT_READY_SE  input  1  consumer accepts result
DOUT_SE  output  32  shifted result
BUSY_SE  output  1  high in SHIFT or DONE

Behaviour:
- One clock; reset is synchronous and active-high.
- State machine: IDLE, SHIFT, DONE.
- Reset values: state IDLE; DOUT_SE = 0; OUT_VALID_SE = 0; BUSY_SE = 0; internal count = 0; IN_READY_SE = 1 after the reset cycle.
- Priority on each edge: RESET, then FLUSH_SE, then normal operation.
- IN_READY_SE = (state == IDLE), combinational. An operand is accepted only when IN_VALID_SE and IN_READY_SE are both high and neither RESET nor FLUSH_SE is asserted.
- On accept: capture DIN_SE into the data register. Capture CMD_SE and SHIFT_VAL_SE into the remaining-count register.
  - Amount 0: go to DONE, DOUT_SE = DIN_SE.
  - Otherwise go to SHIFT.
- SHIFT, each edge: shift the data register by s = min(STEP, remaining); remaining -= s. When remaining reaches 0, go to DONE.
- Latency, accept edge at end of cycle T: OUT_VALID_SE is high from cycle T+1+ceil(n/STEP), where n is the shift amount.
- Fill rules:
  - SLL inserts zeros at bit 0.
  - SRL inserts zeros at bit 31.
  - SRA inserts bit 31 of the data register; the sign is invariant across steps, so this equals the original DIN_SE[31].
- Only SHIFT_VAL_SE[4:0] is used. No rotate. CMD 11 behaves as 10.
- DONE: OUT_VALID_SE = 1. DOUT_SE holds the final value and stays stable while OUT_READY_SE = 0.
  - On OUT_VALID_SE and OUT_READY_SE, go to IDLE.
  - No new operand is accepted in the same cycle (one-cycle bubble between ops).
- OUT_VALID_SE falls on the cycle after the output handshake. DOUT_SE keeps its last value until the next accept overwrites it (don't care when OUT_VALID_SE = 0).
- FLUSH_SE in any state: next state IDLE, OUT_VALID_SE = 0, the result is never presented, DOUT_SE is unchanged.
  - FLUSH_SE in the same cycle as IN_VALID_SE in IDLE: the op is not accepted.
  - FLUSH_SE in DONE with OUT_READY_SE = 1: the handshake is void.
- RESET mid-operation: all state returns to reset values on that edge; no result is emitted.
- IN_VALID_SE while not IDLE: ignored. Upstream must hold its operand until IN_READY_SE is seen.
- Assertions:
  - DOUT_SE is stable while OUT_VALID_SE && !OUT_READY_SE.
  - The remaining count never underflows.
  - STEP is legal (elaboration check).

Decomposition:
- Package shifter_pkg:
  - CMD constants SHIFT_SLL = 2'b00, SHIFT_SRL = 2'b01, SHIFT_SRA = 2'b10.
  - State enum typedef shift_state_t {IDLE, SHIFT, DONE}.
- One sub-module, shift_step: combinational shift of 32 bits by 0..STEP (log2(STEP)+1 stages) with the same fill rules.
- shifter_iter holds the FSM, data/count registers and handshakes.

Test Plan:
- STEP=4, DIN=0x0000_0001, amount 31, CMD 00, OUT_READY=1 -> DOUT=0x8000_0000; OUT_VALID high exactly 9 cycles after the accept edge (8 SHIFT cycles); IN_READY low throughout.
- DIN=0x8000_0000, amount 4: CMD 10 -> 0xF800_0000; CMD 01 -> 0x0800_0000; each valid at T+2. DIN=0x8000_0000, amount 31, CMD 11 -> 0xFFFF_FFFF.
- Amount 0, DIN=0xDEAD_BEEF, any CMD -> DOUT=0xDEAD_BEEF with OUT_VALID at T+1.
- Back-pressure: hold OUT_READY=0 for 5 cycles in DONE with IN_VALID=1 -> DOUT stable, IN_READY=0, second op not accepted. Release -> OUT_VALID falls next cycle, then IN_READY=1 and the second op is accepted.
- Kill cases:
  - FLUSH pulse on the 2nd SHIFT cycle of a 31-bit shift -> OUT_VALID never rises, IN_READY=1 next cycle.
  - RESET pulse mid-SHIFT -> DOUT=0, OUT_VALID=0, BUSY=0 after the reset edge.
- Random regression for STEP in {1, 4, 8}: 1000 ops with random DIN/amount/CMD, random OUT_READY and random FLUSH at 2% -> every non-flushed result matches the single-cycle shifter model, and latency = 1+ceil(n/STEP) cycles plus stall cycles.
